// File: rtl/neureka_package.sv
// Shared types and constants for the NEUREKA store-out path.
// Struct field widths follow the default PE array and memory bandwidth.
package neureka_package;

   localparam int NEUREKA_MEM_BANDWIDTH = 256;
   localparam int NEUREKA_PE_H_DEFAULT  = 4;
   localparam int NEUREKA_PE_W_DEFAULT  = 4;
   localparam int NEUREKA_AW            = 32;
   localparam int NEUREKA_NB            = NEUREKA_MEM_BANDWIDTH / 8;
   localparam int NEUREKA_HW            = $clog2(NEUREKA_PE_H_DEFAULT + 1);
   localparam int NEUREKA_WW            = $clog2(NEUREKA_PE_W_DEFAULT + 1);
   localparam int NEUREKA_KW            = $clog2(NEUREKA_NB + 1);

   typedef struct packed {
      logic                  start;
      logic [NEUREKA_AW-1:0] base_addr;
      logic [NEUREKA_AW-1:0] stride_h;
      logic [NEUREKA_AW-1:0] stride_w;
      logic [NEUREKA_HW-1:0] h_active;
      logic [NEUREKA_WW-1:0] w_active;
      logic [NEUREKA_KW-1:0] kout_bytes;
   } ctrl_streamout_collector_t;

   typedef struct packed {
      logic                  busy;
      logic                  done;
      logic [NEUREKA_HW-1:0] pe_h_idx;
      logic [NEUREKA_WW-1:0] pe_w_idx;
   } flags_streamout_collector_t;

   typedef enum logic [1:0] {
      SOC_IDLE  = 2'd0,
      SOC_RUN   = 2'd1,
      SOC_DRAIN = 2'd2,
      SOC_DONE  = 2'd3
   } soc_state_e;

   // Zero or an out-of-range byte count means the whole beat is valid.
   function automatic logic [NEUREKA_NB-1:0] kout_strb_mask(input logic [NEUREKA_KW-1:0] kout_bytes);
      logic [NEUREKA_NB-1:0] mask;
      mask = '0;
      for (int i = 0; i < NEUREKA_NB; i++) begin
         mask[i] = (i < int'(kout_bytes)) || (kout_bytes == '0) || (int'(kout_bytes) > NEUREKA_NB);
      end
      return mask;
   endfunction

endpackage

// File: rtl/neureka_outfeat_skid.sv
// Two-entry valid/ready buffer carrying {data, strb, addr, last} to the store streamer.
// Outputs come straight from storage so they hold steady while the sink stalls.
module neureka_outfeat_skid #(
   parameter int unsigned DW = 256,
   parameter int unsigned AW = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clear_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [DW-1:0]   in_data_i,
   input  logic [DW/8-1:0] in_strb_i,
   input  logic [AW-1:0]   in_addr_i,
   input  logic            in_last_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [DW-1:0]   out_data_o,
   output logic [DW/8-1:0] out_strb_o,
   output logic [AW-1:0]   out_addr_o,
   output logic            out_last_o
);

   localparam int unsigned EW = DW + DW/8 + AW + 1;

   logic [EW-1:0] mem_q [2];
   logic          rd_q, wr_q;
   logic [1:0]    cnt_q;
   logic          push, pop;

   assign in_ready_o  = (cnt_q != 2'd2);
   assign out_valid_o = (cnt_q != 2'd0);
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i;
   assign {out_data_o, out_strb_o, out_addr_o, out_last_o} = mem_q[rd_q];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         cnt_q    <= 2'd0;
      end else if (clear_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= {in_data_i, in_strb_i, in_addr_i, in_last_i};
            wr_q        <= ~wr_q;
         end
         if (pop) begin
            rd_q <= ~rd_q;
         end
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/neureka_streamout_collector.sv
// Collects the serialized per-PE store_out beats and turns them into addressed, masked write beats.
//
//  state | meaning
//  IDLE  | waiting for start; ctrl latched on start
//  RUN   | accepting PE beats in (h, w) order
//  DRAIN | last beat taken, waiting for the buffer to empty
//  DONE  | one-cycle done pulse, back to IDLE
module neureka_streamout_collector
   import neureka_package::*;
#(
   parameter int unsigned DW   = NEUREKA_MEM_BANDWIDTH,
   parameter int unsigned PE_H = NEUREKA_PE_H_DEFAULT,
   parameter int unsigned PE_W = NEUREKA_PE_W_DEFAULT,
   parameter int unsigned AW   = NEUREKA_AW
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clear_i,
   input  ctrl_streamout_collector_t  ctrl_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [DW-1:0]              in_data_i,
   input  logic [DW/8-1:0]            in_strb_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [DW-1:0]              out_data_o,
   output logic [DW/8-1:0]            out_strb_o,
   output logic [AW-1:0]              out_addr_o,
   output logic                       out_last_o,
   output flags_streamout_collector_t flags_o
);

   localparam int unsigned HW = $clog2(PE_H + 1);
   localparam int unsigned WW = $clog2(PE_W + 1);

   soc_state_e      state_q, state_d;
   logic [AW-1:0]   stride_h_q, stride_w_q, row_addr_q, col_addr_q;
   logic [HW-1:0]   h_act_q, h_q;
   logic [WW-1:0]   w_act_q, w_q;
   logic [DW/8-1:0] strb_mask_q;
   logic            skid_in_ready, push, row_end, beat_last, start_ok;

   assign start_ok   = (state_q == SOC_IDLE) && ctrl_i.start;
   assign in_ready_o = (state_q == SOC_RUN) && skid_in_ready;
   assign push       = in_valid_i && in_ready_o;
   assign row_end    = (w_q == w_act_q - WW'(1));
   assign beat_last  = row_end && (h_q == h_act_q - HW'(1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= SOC_IDLE;
      end else if (clear_i) begin
         state_q <= SOC_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SOC_IDLE: begin
            if (ctrl_i.start) begin
               if ((ctrl_i.h_active == '0) || (ctrl_i.w_active == '0)) state_d = SOC_DONE;
               else                                                     state_d = SOC_RUN;
            end
         end
         SOC_RUN:   if (push && beat_last) state_d = SOC_DRAIN;
         SOC_DRAIN: if (!out_valid_o)      state_d = SOC_DONE;
         SOC_DONE:  state_d = SOC_IDLE;
         default:   state_d = SOC_IDLE;
      endcase
   end

   // Address is built incrementally: row base steps by stride_h, column by stride_w.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stride_h_q  <= '0;
         stride_w_q  <= '0;
         row_addr_q  <= '0;
         col_addr_q  <= '0;
         h_act_q     <= '0;
         w_act_q     <= '0;
         h_q         <= '0;
         w_q         <= '0;
         strb_mask_q <= '0;
      end else if (clear_i) begin
         stride_h_q  <= '0;
         stride_w_q  <= '0;
         row_addr_q  <= '0;
         col_addr_q  <= '0;
         h_act_q     <= '0;
         w_act_q     <= '0;
         h_q         <= '0;
         w_q         <= '0;
         strb_mask_q <= '0;
      end else if (start_ok) begin
         stride_h_q  <= ctrl_i.stride_h;
         stride_w_q  <= ctrl_i.stride_w;
         row_addr_q  <= ctrl_i.base_addr;
         col_addr_q  <= ctrl_i.base_addr;
         h_act_q     <= ctrl_i.h_active;
         w_act_q     <= ctrl_i.w_active;
         h_q         <= '0;
         w_q         <= '0;
         strb_mask_q <= kout_strb_mask(ctrl_i.kout_bytes);
      end else if (push && !beat_last) begin
         if (row_end) begin
            w_q        <= '0;
            h_q        <= h_q + HW'(1);
            row_addr_q <= row_addr_q + stride_h_q;
            col_addr_q <= row_addr_q + stride_h_q;
         end else begin
            w_q        <= w_q + WW'(1);
            col_addr_q <= col_addr_q + stride_w_q;
         end
      end
   end

   neureka_outfeat_skid #(
      .DW (DW),
      .AW (AW)
   ) i_skid (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (clear_i),
      .in_valid_i  (push),
      .in_ready_o  (skid_in_ready),
      .in_data_i   (in_data_i),
      .in_strb_i   (in_strb_i & strb_mask_q),
      .in_addr_i   (col_addr_q),
      .in_last_i   (beat_last),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_strb_o  (out_strb_o),
      .out_addr_o  (out_addr_o),
      .out_last_o  (out_last_o)
   );

   always_comb begin
      flags_o          = '0;
      flags_o.busy     = (state_q != SOC_IDLE);
      flags_o.done     = (state_q == SOC_DONE);
      flags_o.pe_h_idx = h_q;
      flags_o.pe_w_idx = w_q;
   end

endmodule
